// File: rtl/mem_access_unit.sv
// mem_access_unit: EX/MEM to MEM/WB stage.
// Resolves branches/jumps, runs loads/stores over a req/ack bus.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              branch_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       imm_i,
  input  logic [31:0]       alu_result_i,
  input  logic [31:0]       rs1_data_i,
  input  logic [31:0]       rs2_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic              dmem_err_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              stall_o,
  output logic              load_valid_o,
  output logic [31:0]       load_data_o,
  output logic              exc_o,
  output logic [1:0]        exc_cause_o,
  output logic [31:0]       exc_addr_o,
  output logic              redirect_o,
  output logic [1:0]        pc_sel_o,
  output logic [31:0]       target_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam int CW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            fault_q, fault_d;

  logic        live, idle, bus, done;
  logic        mem_op, is_half, is_word, mis;
  logic        acc_go, mis_exc, tmo;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        br_taken;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Rst gating keeps every output low while reset is held.
  assign live    = valid_i & ~flush_i & rst_n_i;
  assign idle    = (state_q == S_IDLE);
  assign bus     = (state_q == S_BUS) & rst_n_i;
  assign done    = (state_q == S_DONE) & rst_n_i;
  assign mem_op  = mem_read_i | mem_write_i;
  assign is_half = ~funct3_i[1] & funct3_i[0];
  assign is_word = funct3_i[1];
  assign mis     = (is_half & alu_result_i[0])
                 | (is_word & |alu_result_i[1:0]);
  assign acc_go  = idle & live & mem_op & ~mis;
  assign mis_exc = idle & live & mem_op & mis;
  assign tmo     = TMO_EN && (cnt_q == TC_LAST);

  // Store lane steering: replicate data, select byte enables.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = 32'h0;
    if (!mem_read_i) begin
      unique case (1'b1)
        is_word: begin
          st_be    = 4'b1111;
          st_wdata = rs2_data_i;
        end
        is_half: begin
          st_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{rs2_data_i[15:0]}};
        end
        default: begin
          st_be    = 4'b0001 << alu_result_i[1:0];
          st_wdata = {4{rs2_data_i[7:0]}};
        end
      endcase
    end
  end

  // Branch condition from true operand comparison.
  always_comb begin
    br_taken = 1'b0;
    case (funct3_i)
      3'b000:  br_taken = (rs1_data_i == rs2_data_i);
      3'b001:  br_taken = (rs1_data_i != rs2_data_i);
      3'b100:  br_taken =
        ($signed(rs1_data_i) < $signed(rs2_data_i));
      3'b101:  br_taken =
        ($signed(rs1_data_i) >= $signed(rs2_data_i));
      3'b110:  br_taken = (rs1_data_i < rs2_data_i);
      3'b111:  br_taken = (rs1_data_i >= rs2_data_i);
      default: br_taken = 1'b0;
    endcase
  end

  // Load lane select and extension from the captured word.
  always_comb begin
    ld_byte = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  // Next-state logic for the access FSM and its latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc_go) begin
          state_d = S_BUS;
          cnt_d   = '0;
          addr_d  = alu_result_i;
          be_d    = st_be;
          wdata_d = st_wdata;
          we_d    = ~mem_read_i;
          f3_d    = funct3_i;
          fault_d = 1'b0;
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_ack_i) begin
          rdata_d = dmem_rdata_i;
          fault_d = dmem_err_i;
          state_d = S_DONE;
        end else if (tmo) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latch registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Output decode: bus, stall, results, exceptions, redirects.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = 32'h0;
    stall_o      = acc_go | bus;
    load_valid_o = 1'b0;
    load_data_o  = 32'h0;
    exc_o        = 1'b0;
    exc_cause_o  = 2'b00;
    exc_addr_o   = 32'h0;
    redirect_o   = 1'b0;
    pc_sel_o     = 2'b00;
    target_o     = 32'h0;
    if (bus) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = we_q;
      dmem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
      dmem_be_o    = be_q;
      dmem_wdata_o = wdata_q;
    end
    if (done && !flush_i) begin
      if (fault_q) begin
        exc_o       = 1'b1;
        exc_cause_o = 2'b11;
        exc_addr_o  = addr_q;
      end else if (!we_q) begin
        load_valid_o = 1'b1;
        load_data_o  = ld_ext;
      end
    end
    if (mis_exc) begin
      exc_o       = 1'b1;
      exc_cause_o = mem_read_i ? 2'b01 : 2'b10;
      exc_addr_o  = alu_result_i;
    end
    if (idle && live) begin
      if (opcode_i == OP_JALR) begin
        redirect_o = 1'b1;
        pc_sel_o   = 2'b10;
        target_o   = alu_result_i & ~32'h1;
      end else if (opcode_i == OP_JAL ||
                   (branch_i && br_taken)) begin
        redirect_o = 1'b1;
        pc_sel_o   = 2'b01;
        target_o   = pc_i + imm_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench.
// TIMEOUT_CYCLES=4 so the timeout boundary is reachable.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        valid, flush;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        branch, mrd, mwr;
  logic [31:0] pc, imm, alu, rs1, rs2;
  logic        req, we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack, err;
  logic [31:0] rdata;
  logic        stall, lvalid;
  logic [31:0] ldata;
  logic        exc;
  logic [1:0]  cause;
  logic [31:0] eaddr;
  logic        redir;
  logic [1:0]  psel;
  logic [31:0] tgt;

  int n_run = 0;
  int n_fail = 0;

  mem_access_unit #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .valid_i(valid), .flush_i(flush),
    .opcode_i(opcode), .funct3_i(funct3),
    .branch_i(branch), .mem_read_i(mrd),
    .mem_write_i(mwr),
    .pc_i(pc), .imm_i(imm), .alu_result_i(alu),
    .rs1_data_i(rs1), .rs2_data_i(rs2),
    .dmem_req_o(req), .dmem_we_o(we),
    .dmem_addr_o(addr), .dmem_be_o(be),
    .dmem_wdata_o(wdata),
    .dmem_ack_i(ack), .dmem_err_i(err),
    .dmem_rdata_i(rdata),
    .stall_o(stall),
    .load_valid_o(lvalid), .load_data_o(ldata),
    .exc_o(exc), .exc_cause_o(cause),
    .exc_addr_o(eaddr),
    .redirect_o(redir), .pc_sel_o(psel),
    .target_o(tgt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid = 0; flush = 0; opcode = 0; funct3 = 0;
    branch = 0; mrd = 0; mwr = 0;
    pc = 0; imm = 0; alu = 0; rs1 = 0; rs2 = 0;
    ack = 0; err = 0; rdata = 0;
  endtask

  task automatic ld(input logic [2:0] f3,
                    input logic [31:0] a);
    clr();
    valid = 1; mrd = 1; opcode = 7'b0000011;
    funct3 = f3; alu = a;
  endtask

  task automatic st(input logic [2:0] f3,
                    input logic [31:0] a,
                    input logic [31:0] d);
    clr();
    valid = 1; mwr = 1; opcode = 7'b0100011;
    funct3 = f3; alu = a; rs2 = d;
  endtask

  task automatic br(input logic [2:0] f3);
    clr();
    valid = 1; branch = 1; opcode = 7'b1100011;
    funct3 = f3; pc = 32'h100; imm = 32'h40;
    rs1 = 32'hFFFF_FFFF; rs2 = 32'h1;
  endtask

  initial begin
    clr();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    check("rst_stall", stall, 0);
    check("rst_req", req, 0);
    check("rst_be", be, 0);
    check("rst_psel", psel, 0);
    check("rst_exc", exc, 0);
    check("rst_lv", lvalid, 0);
    tick();

    // LB 0x1003, zero-wait
    ld(3'b000, 32'h1003);
    #1 check("lb_c0_stall", stall, 1);
    check("lb_c0_req", req, 0);
    tick();
    clr(); ack = 1; rdata = 32'h80FF_1234;
    #1 check("lb_c1_req", req, 1);
    check("lb_c1_addr", addr, 32'h1000);
    check("lb_c1_we", we, 0);
    check("lb_c1_stall", stall, 1);
    tick();
    ack = 0;
    #1 check("lb_c2_lv", lvalid, 1);
    check("lb_c2_data", ldata, 32'hFFFF_FF80);
    check("lb_c2_stall", stall, 0);
    check("lb_c2_req", req, 0);
    tick();
    check("lb_c3_lv", lvalid, 0);

    // SH 0xABCD at 0x2002
    st(3'b001, 32'h2002, 32'h0000_ABCD);
    #1 check("sh_c0_stall", stall, 1);
    tick();
    clr(); ack = 1;
    #1 check("sh_req", req, 1);
    check("sh_addr", addr, 32'h2000);
    check("sh_be", be, 4'b1100);
    check("sh_wdata", wdata, 32'hABCD_ABCD);
    check("sh_we", we, 1);
    tick();
    ack = 0;
    #1 check("sh_done_lv", lvalid, 0);
    check("sh_done_req", req, 0);
    tick();

    // SB 0x5A at 0x2001
    st(3'b000, 32'h2001, 32'h1234_565A);
    tick();
    clr(); ack = 1;
    #1 check("sb_be", be, 4'b0010);
    check("sb_wdata", wdata, 32'h5A5A_5A5A);
    tick();
    clr();
    tick();

    // LW misaligned at 0x3001
    ld(3'b010, 32'h3001);
    #1 check("lwm_exc", exc, 1);
    check("lwm_cause", cause, 2'b01);
    check("lwm_addr", eaddr, 32'h3001);
    check("lwm_req", req, 0);
    check("lwm_stall", stall, 0);
    tick();
    clr();
    #1 check("lwm_noreq", req, 0);
    tick();

    // SW misaligned at 0x6002
    st(3'b010, 32'h6002, 32'h0);
    #1 check("swm_cause", cause, 2'b10);
    check("swm_exc", exc, 1);
    tick();

    // Branches and jumps
    br(3'b100);
    #1 check("blt_redir", redir, 1);
    check("blt_psel", psel, 2'b01);
    check("blt_tgt", tgt, 32'h140);
    br(3'b110);
    #1 check("bltu_redir", redir, 0);
    br(3'b101);
    #1 check("bge_redir", redir, 0);
    br(3'b010);
    #1 check("bill_redir", redir, 0);
    clr(); valid = 1; opcode = 7'b1100111;
    alu = 32'h2345;
    #1 check("jalr_psel", psel, 2'b10);
    check("jalr_tgt", tgt, 32'h2344);
    clr(); valid = 1; opcode = 7'b1101111;
    pc = 32'h200; imm = 32'hFFFF_FFF0;
    #1 check("jal_tgt", tgt, 32'h1F0);
    flush = 1;
    #1 check("jal_flush", redir, 0);
    tick();

    // LW timeout, 4 cycles without ack
    ld(3'b010, 32'h4000);
    tick();
    clr();
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("tmo_req%0d", i), req, 1);
      if (i == 0) begin
        br(3'b100);
        #1 check("bus_redir", redir, 0);
        clr();
      end
      tick();
    end
    #1 check("tmo_req_drop", req, 0);
    check("tmo_exc", exc, 1);
    check("tmo_cause", cause, 2'b11);
    check("tmo_addr", eaddr, 32'h4000);
    check("tmo_lv", lvalid, 0);
    check("tmo_stall", stall, 0);
    tick();
    check("tmo_exc_off", exc, 0);

    // LW with ack at 3 waits (terminal count)
    ld(3'b010, 32'h4004);
    tick();
    clr();
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("w3_stall%0d", i), stall, 1);
      tick();
    end
    ack = 1; rdata = 32'h1234_5678;
    #1 check("w3_req", req, 1);
    tick();
    ack = 0;
    #1 check("w3_lv", lvalid, 1);
    check("w3_data", ldata, 32'h1234_5678);
    check("w3_exc", exc, 0);
    tick();

    // LHU at 0x7002, ack with err -> access fault
    ld(3'b101, 32'h7002);
    tick();
    clr(); ack = 1; err = 1;
    tick();
    clr();
    #1 check("err_exc", exc, 1);
    check("err_cause", cause, 2'b11);
    check("err_lv", lvalid, 0);
    tick();

    // LHU at 0x7002 normal
    ld(3'b101, 32'h7002);
    tick();
    clr(); ack = 1; rdata = 32'h9876_0000;
    tick();
    clr();
    #1 check("lhu_data", ldata, 32'h0000_9876);
    tick();

    // Flush during BUS suppresses load_valid
    ld(3'b010, 32'h8000);
    tick();
    clr(); ack = 1; flush = 1;
    #1 check("fl_req", req, 1);
    tick();
    ack = 0;
    #1 check("fl_lv", lvalid, 0);
    tick();
    clr();

    // Reset during BUS, then late ack
    ld(3'b010, 32'h5000);
    tick();
    clr();
    #1 check("rb_req", req, 1);
    rst_n = 0;
    tick();
    rst_n = 1; ack = 1; rdata = 32'hDEAD_BEEF;
    #1 check("rb_req0", req, 0);
    check("rb_stall", stall, 0);
    check("rb_lv", lvalid, 0);
    check("rb_be", be, 0);
    tick();
    ack = 0;
    #1 check("rb_lv2", lvalid, 0);
    check("rb_exc", exc, 0);
    check("rb_req2", req, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
